// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared FFT definitions: default sample width / point count,
//               frame-buffer state encoding and an index bit-reversal helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

   localparam int FFT_WIDTH  = 8;
   localparam int FFT_POINTS = 8;

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } fb_state_t;

   // Reverses the low nbits of index; used for decimation-in-time ordering.
   function automatic int unsigned bitrev(input int unsigned index,
                                          input int unsigned nbits);
      int unsigned r;
      r = 0;
      for (int unsigned b = 0; b < nbits; b++) begin
         r = (r << 1) | ((index >> b) & 32'd1);
      end
      return r;
   endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_buffer
// Description : Collects DEPTH serial samples into a parallel frame for the
//               butterfly stage, with valid/ready handshakes on both sides.
//               Define FFT_BITREV_EN for bit-reversed output slot order.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_buffer
   import fft_pkg::*;
#(
   parameter int WIDTH = FFT_WIDTH,
   parameter int DEPTH = FFT_POINTS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [WIDTH*DEPTH-1:0]       frame_data,
   output logic                         frame_valid,
   input  logic                         frame_ready,
   output logic [$clog2(DEPTH+1)-1:0]   fill_count
);

   localparam int c_LOG2 = $clog2(DEPTH);
   localparam int c_CW   = $clog2(DEPTH + 1);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(DEPTH - 1);

   fb_state_t          r_state;
   logic [c_CW-1:0]    r_fill_count;
   logic [WIDTH-1:0]   r_slot [DEPTH];

   logic               w_frame_valid;
   logic               w_in_ready;
   logic               w_sample_acc;
   logic [c_LOG2-1:0]  w_wr_idx;

   assign w_frame_valid = (r_state == ST_FULL);
   assign w_in_ready    = !w_frame_valid || frame_ready;
   assign w_sample_acc  = in_valid && w_in_ready;
   assign w_wr_idx      = r_fill_count[c_LOG2-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_FILL;
         r_fill_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_slot[i] <= '0;
         end
      end else if (flush) begin
         r_state      <= ST_FILL;
         r_fill_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_slot[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_FILL: begin
               if (w_sample_acc) begin
                  r_slot[w_wr_idx] <= in_data;
                  r_fill_count     <= r_fill_count + 1'b1;
                  if (r_fill_count == c_LAST) begin
                     r_state <= ST_FULL;
                  end
               end
            end
            ST_FULL: begin
               // In FULL a sample can only be accepted alongside the frame release.
               if (frame_ready) begin
                  r_state <= ST_FILL;
                  if (in_valid) begin
                     r_slot[0]    <= in_data;
                     r_fill_count <= c_CW'(1);
                  end else begin
                     r_fill_count <= '0;
                  end
               end
            end
            default: begin
               r_state      <= ST_FILL;
               r_fill_count <= '0;
            end
         endcase
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_slot
`ifdef FFT_BITREV_EN
      localparam int unsigned c_SRC = bitrev(k, c_LOG2);
`else
      localparam int unsigned c_SRC = k;
`endif
      assign frame_data[k*WIDTH +: WIDTH] = r_slot[c_SRC];
   end

   assign in_ready    = w_in_ready;
   assign frame_valid = w_frame_valid;
   assign fill_count  = r_fill_count;

endmodule : fft_frame_buffer
`default_nettype wire
